// File: rtl/attention_softmax_rownorm.sv
// Row normaliser for attention: reads E = exp(S - rowmax), sums each row in FP32,
// and writes P = E * (1/rowsum) into a local TxT buffer readable by the P.V stage.
module attention_softmax_rownorm #(
  parameter int T      = 4,
  parameter int DATA_W = 32,
  parameter int ROW_W  = (T <= 1) ? 1 : $clog2(T),
  parameter int COL_W  = (T <= 1) ? 1 : $clog2(T)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [T-1:0]      pad_valid,
  output logic              busy,
  output logic              done,
  output logic              e_re,
  output logic [ROW_W-1:0]  e_tq,
  output logic [COL_W-1:0]  e_tk,
  input  logic [DATA_W-1:0] e_rdata,
  input  logic              e_rvalid,
  input  logic              p_re,
  input  logic [ROW_W-1:0]  p_tq,
  input  logic [COL_W-1:0]  p_tk,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_rvalid
);

  // Shared RNE rounding/packing; subnormal results flush to signed zero.
  function automatic logic [31:0] fp_round(input logic s, input logic signed [11:0] e,
                                           input logic [23:0] m, input logic g, input logic st);
    logic [24:0] mr;
    logic signed [11:0] er;
    mr = {1'b0, m} + {24'd0, g & (st | m[0])};
    er = e;
    if (mr[24]) begin
      mr = {1'b0, mr[24:1]};
      er = er + 12'sd1;
    end
    if (er <= 12'sd0)        fp_round = {s, 31'd0};
    else if (er >= 12'sd255) fp_round = {s, 8'hff, 23'd0};
    else                     fp_round = {s, er[7:0], mr[22:0]};
  endfunction

  function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [26:0] xa, xb, sh, dif;
    logic [27:0] sm;
    logic [7:0]  d;
    logic signed [11:0] e;
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    x = a;
    y = b;
    if (a[30:0] < b[30:0]) begin
      x = b;
      y = a;
    end
    d  = x[30:23] - y[30:23];
    xa = {1'b1, x[22:0], 3'b000};
    xb = {1'b1, y[22:0], 3'b000};
    // Bits shifted out of the smaller operand collapse into a sticky lsb.
    if (d >= 8'd27) sh = 27'd1;
    else begin
      sh = xb >> d;
      if ((sh << d) != xb) sh[0] = 1'b1;
    end
    e = $signed({4'd0, x[30:23]});
    if (x[31] == y[31]) begin
      sm = {1'b0, xa} + {1'b0, sh};
      if (sm[27]) begin
        sm = {1'b0, sm[27:2], sm[1] | sm[0]};
        e  = e + 12'sd1;
      end
      dif = sm[26:0];
    end else begin
      dif = xa - sh;
      if (dif == 27'd0) return 32'd0;
      for (int i = 0; i < 26; i++) begin
        if (!dif[26]) begin
          dif = dif << 1;
          e   = e - 12'sd1;
        end
      end
    end
    return fp_round(x[31], e, dif[26:3], dif[2], |dif[1:0]);
  endfunction

  function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic signed [11:0] e;
    logic s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({4'd0, a[30:23]}) + $signed({4'd0, b[30:23]}) - 12'sd127;
    if (p[47]) return fp_round(s, e + 12'sd1, p[47:24], p[23], |p[22:0]);
    return fp_round(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp32_div(input logic [31:0] a, input logic [31:0] b);
    logic [49:0] num, den, q, r;
    logic signed [11:0] e;
    logic s;
    s = a[31] ^ b[31];
    if (b[30:23] == 8'd0) return {s, 8'hff, 23'd0};
    if (a[30:23] == 8'd0) return {s, 31'd0};
    num = {1'b1, a[22:0], 26'd0};
    den = {26'd0, 1'b1, b[22:0]};
    q   = num / den;
    r   = num % den;
    e   = $signed({4'd0, a[30:23]}) - $signed({4'd0, b[30:23]}) + 12'sd127;
    if (q[26]) return fp_round(s, e, q[26:3], q[2], (|q[1:0]) | (r != 50'd0));
    return fp_round(s, e - 12'sd1, q[25:2], q[1], q[0] | (r != 50'd0));
  endfunction

  typedef enum logic [2:0] {
    IDLE, SUM_REQ, SUM_WAIT, RECIP, NORM_REQ, NORM_WAIT, NEXT_ROW, DONE
  } state_t;

  state_t state, state_n;

  logic [T-1:0][T-1:0][DATA_W-1:0] pbuf;
  logic [T-1:0]      pad;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col, col_adv;
  logic [DATA_W-1:0] sum, recip, sum_next, recip_next, prod;
  logic              zero_row, last_col, last_row, col_ok;

  assign last_col   = (col == COL_W'(T - 1));
  assign last_row   = (row == ROW_W'(T - 1));
  assign col_adv    = last_col ? '0 : col + COL_W'(1);
  assign col_ok     = pad[col];
  assign sum_next   = fp32_add(sum, e_rdata);
  assign recip_next = fp32_div(32'h3f80_0000, sum);
  assign prod       = fp32_mul(e_rdata, recip);

  assign e_tq = row;
  assign e_tk = col;
  assign e_re = (state == SUM_REQ && col_ok) || (state == NORM_REQ && col_ok && !zero_row);
  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start) state_n = SUM_REQ;
      SUM_REQ:   if (!col_ok) state_n = last_col ? RECIP : SUM_REQ;
                 else         state_n = SUM_WAIT;
      SUM_WAIT:  if (e_rvalid) state_n = last_col ? RECIP : SUM_REQ;
      RECIP:     state_n = NORM_REQ;
      NORM_REQ:  if (zero_row || !col_ok) state_n = last_col ? NEXT_ROW : NORM_REQ;
                 else                     state_n = NORM_WAIT;
      NORM_WAIT: if (e_rvalid) state_n = last_col ? NEXT_ROW : NORM_REQ;
      NEXT_ROW:  state_n = last_row ? DONE : SUM_REQ;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pbuf     <= '0;
      pad      <= '0;
      row      <= '0;
      col      <= '0;
      sum      <= '0;
      recip    <= '0;
      zero_row <= 1'b0;
      p_rvalid <= 1'b0;
      p_rdata  <= '0;
    end else begin
      // Read port sees the live buffer, so partially written rows are visible.
      p_rvalid <= p_re;
      if (p_re) p_rdata <= pbuf[p_tq][p_tk];
      case (state)
        IDLE: if (start) begin
          pad <= pad_valid;
          row <= '0;
          col <= '0;
          sum <= '0;
        end
        SUM_REQ: if (!col_ok) col <= col_adv;
        SUM_WAIT: if (e_rvalid) begin
          sum <= sum_next;
          col <= col_adv;
        end
        RECIP: begin
          zero_row <= (sum[30:0] == 31'd0);
          recip    <= (sum[30:0] == 31'd0) ? '0 : recip_next;
          col      <= '0;
        end
        NORM_REQ: if (zero_row || !col_ok) begin
          pbuf[row][col] <= '0;
          col            <= col_adv;
        end
        NORM_WAIT: if (e_rvalid) begin
          pbuf[row][col] <= prod;
          col            <= col_adv;
        end
        NEXT_ROW: begin
          if (!last_row) row <= row + ROW_W'(1);
          col <= '0;
          sum <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_attention_softmax_rownorm.sv
// Directed bench for attention_softmax_rownorm with a variable-latency E memory model.
module tb_attention_softmax_rownorm;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst, start, p_re;
  logic [3:0]  pad_valid;
  logic        busy, done, e_re, p_rvalid;
  logic [1:0]  e_tq, e_tk, p_tq, p_tk;
  logic [31:0] e_rdata = 32'h0;
  logic        e_rvalid = 1'b0;
  logic [31:0] p_rdata;

  attention_softmax_rownorm #(.T(T), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .pad_valid(pad_valid),
    .busy(busy), .done(done),
    .e_re(e_re), .e_tq(e_tq), .e_tk(e_tk), .e_rdata(e_rdata), .e_rvalid(e_rvalid),
    .p_re(p_re), .p_tq(p_tq), .p_tk(p_tk), .p_rdata(p_rdata), .p_rvalid(p_rvalid)
  );

  always #5 clk = ~clk;

  logic [31:0] emem [T][T];
  logic [31:0] pexp [T][T];
  logic [3:0]  pad_cur = 4'h0;
  int          lat_min = 1, lat_max = 1;
  bit          garbage = 1'b0;
  int          n_ere = 0, n_overlap = 0, n_badpad = 0;
  int          n_chk = 0, n_fail = 0;

  // E memory: answers each e_re after lat cycles; rdata is noise when not valid.
  bit          pend = 1'b0;
  int          wcnt = 0, mlat = 1;
  logic [1:0]  rq = 2'd0, rk = 2'd0;
  always @(posedge clk) begin
    e_rvalid <= 1'b0;
    e_rdata  <= garbage ? $urandom : 32'h0;
    if (pend) begin
      if (wcnt <= 1) begin
        e_rvalid <= 1'b1;
        e_rdata  <= emem[rq][rk];
        pend     <= 1'b0;
      end else wcnt <= wcnt - 1;
    end
    if (e_re) begin
      n_ere++;
      if (pend || e_rvalid) n_overlap++;
      if (!pad_cur[e_tk]) n_badpad++;
      mlat = $urandom_range(lat_max, lat_min);
      if (mlat == 1) begin
        e_rvalid <= 1'b1;
        e_rdata  <= emem[e_tq][e_tk];
      end else begin
        pend <= 1'b1;
        rq   <= e_tq;
        rk   <= e_tk;
        wcnt <= mlat - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rdp(input int q, input int k, output logic [31:0] d, output logic v);
    p_tq = 2'(q);
    p_tk = 2'(k);
    p_re = 1'b1;
    @(posedge clk); #1;
    p_re = 1'b0;
    d = p_rdata;
    v = p_rvalid;
  endtask

  task automatic chk_p(input string tag);
    logic [31:0] d;
    logic        v;
    int          vbad = 0;
    for (int r = 0; r < T; r++)
      for (int k = 0; k < T; k++) begin
        rdp(r, k, d, v);
        if (v !== 1'b1) vbad++;
        chk($sformatf("%s P[%0d][%0d]", tag, r, k), d, pexp[r][k]);
      end
    chk({tag, " p_rvalid"}, vbad, 0);
  endtask

  // Start pulse, then wait for done; cyc counts cycles inclusive of start and done.
  task automatic run(input logic [3:0] pad, input bit mon, input bit dbl, output int cyc);
    int          mbad = 0;
    logic [31:0] last = 32'h0;
    bit          seen = 1'b0;
    pad_cur   = pad;
    pad_valid = pad;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 2;
    while (!done && cyc < 2000) begin
      if (dbl && cyc == 20) begin
        start     = 1'b1;
        pad_valid = 4'h0;
      end else start = 1'b0;
      if (mon) begin
        p_re = 1'b1;
        p_tq = 2'd3;
        p_tk = 2'd3;
      end
      @(posedge clk); #1;
      cyc++;
      if (mon) begin
        if (p_rvalid !== 1'b1) mbad++;
        if (p_rdata === pexp[3][3]) seen = 1'b1;
        else if (p_rdata !== 32'h0 || seen) mbad++;
        last = p_rdata;
      end
    end
    start = 1'b0;
    p_re  = 1'b0;
    if (!done) chk("done timeout", {31'd0, done}, 32'd1);
    if (mon) begin
      chk("mon stream", mbad, 0);
      chk("mon final", last, pexp[3][3]);
    end
    @(posedge clk); #1;
  endtask

  task automatic load_a();
    for (int r = 0; r < T; r++) begin
      emem[r][0] = 32'h3f800000; emem[r][1] = 32'h3f000000;
      emem[r][2] = 32'h3e800000; emem[r][3] = 32'h3e800000;
      pexp[r][0] = 32'h3f000000; pexp[r][1] = 32'h3e800000;
      pexp[r][2] = 32'h3e000000; pexp[r][3] = 32'h3e000000;
    end
  endtask

  initial begin
    int          cyc, e0, cnt, n2;
    logic [31:0] d;
    logic        v;
    rst = 1'b1; start = 1'b0; pad_valid = 4'h0;
    p_re = 1'b0; p_tq = 2'd0; p_tk = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst done", {31'd0, done}, 0);
    chk("rst e_re", {31'd0, e_re}, 0);
    chk("rst p_rvalid", {31'd0, p_rvalid}, 0);
    chk("rst e_tq/e_tk", {28'd0, e_tq, e_tk}, 0);
    chk("rst p_rdata", p_rdata, 0);
    rst = 1'b0;
    rdp(1, 2, d, v);
    chk("rst P[1][2]", d, 0);
    chk("rst read valid", {31'd0, v}, 1);

    // Full rows, latency 1.
    load_a();
    e0 = n_ere;
    run(4'hF, 1'b0, 1'b0, cyc);
    chk("A cycles", cyc, 74);
    chk("A e_re count", n_ere - e0, 32);
    chk_p("A");

    // Padded key column 3.
    for (int r = 0; r < T; r++) begin
      emem[r][0] = 32'h3f800000; emem[r][1] = 32'h3f800000;
      emem[r][2] = 32'h3f800000; emem[r][3] = 32'h40a00000;
      pexp[r][0] = 32'h3eaaaaab; pexp[r][1] = 32'h3eaaaaab;
      pexp[r][2] = 32'h3eaaaaab; pexp[r][3] = 32'h0;
    end
    e0 = n_ere;
    run(4'b0111, 1'b0, 1'b0, cyc);
    chk("B cycles", cyc, 66);
    chk("B e_re count", n_ere - e0, 24);
    chk("B padded reads", n_badpad, 0);
    chk_p("B");

    // Everything padded.
    for (int r = 0; r < T; r++)
      for (int k = 0; k < T; k++) pexp[r][k] = 32'h0;
    e0 = n_ere;
    run(4'h0, 1'b0, 1'b0, cyc);
    chk("C cycles", cyc, 42);
    chk("C e_re count", n_ere - e0, 0);
    chk_p("C");

    // Random latency, noisy rdata, a zero row, a stray start, and live P reads.
    load_a();
    for (int k = 0; k < T; k++) begin
      emem[2][k] = 32'h0;
      pexp[2][k] = 32'h0;
    end
    emem[3][0] = 32'h40000000; emem[3][1] = 32'h40000000;
    emem[3][2] = 32'h0;        emem[3][3] = 32'h40800000;
    pexp[3][0] = 32'h3e800000; pexp[3][1] = 32'h3e800000;
    pexp[3][2] = 32'h0;        pexp[3][3] = 32'h3f000000;
    lat_min = 1; lat_max = 4; garbage = 1'b1;
    e0 = n_ere;
    run(4'hF, 1'b1, 1'b1, cyc);
    chk("D e_re count", n_ere - e0, 28);
    chk_p("D");

    // Reset while row 2 waits on its first normalise read; the reply lands in IDLE.
    load_a();
    lat_min = 3; lat_max = 3; garbage = 1'b0;
    pad_cur = 4'hF; pad_valid = 4'hF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n2 = 0; cnt = 0;
    while (n2 < 5 && cnt < 500) begin
      if (e_re && e_tq == 2'd2) n2++;
      if (n2 < 5) begin
        @(posedge clk); #1;
      end
      cnt++;
    end
    chk("E reached row2 norm", n2, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("E rst busy", {31'd0, busy}, 0);
    chk("E rst e_re", {31'd0, e_re}, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("E idle after late rvalid", {31'd0, busy}, 0);
    rdp(0, 0, d, v);
    chk("E P[0][0] cleared", d, 0);
    rdp(1, 3, d, v);
    chk("E P[1][3] cleared", d, 0);
    lat_min = 1; lat_max = 1;
    run(4'hF, 1'b0, 1'b0, cyc);
    chk("E rerun cycles", cyc, 74);
    chk_p("E");

    chk("overlapping reads", n_overlap, 0);
    chk("padded reads total", n_badpad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
